// File: rtl/memory_bus_responder_pkg.sv
// mem_bus_pkg: responder FSM state type and default bus widths shared by the responder slice
package mem_bus_pkg;
  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_DATA_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, RESP, RESP_FAULT} responder_state_t;
endpackage

// File: rtl/memory_bus_responder_if.sv
// memory_bus: CPU data-memory bus; master drives addr/write_data/dispatch_*, slave returns read_data/read_valid/write_done/busy/addr_fault/dropped
interface memory_bus import mem_bus_pkg::*; #(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  dispatch_read;
  logic                  dispatch_write;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  write_done;
  logic                  busy;
  logic                  addr_fault;
  logic                  dropped;
  modport master (
    output addr, write_data, dispatch_read, dispatch_write,
    input  read_data, read_valid, write_done, busy, addr_fault, dropped
  );
  modport slave (
    input  addr, write_data, dispatch_read, dispatch_write,
    output read_data, read_valid, write_done, busy, addr_fault, dropped
  );
endinterface

// File: rtl/memory_bus_responder_counter.sv
// mem_latency_counter: loads LATENCY on start and counts down to 0; done marks the last wait cycle (clk_in, rst_in, start in; done out)
module mem_latency_counter #(
  parameter int LATENCY = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic start,
  output logic done
);
  logic [2:0] cnt;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) cnt <= '0;
    else cnt <= start ? 3'(LATENCY) : (cnt != 3'd0 ? cnt - 3'd1 : cnt);
  assign done = cnt == 3'd1;
endmodule

// File: rtl/memory_bus_responder.sv
// memory_bus_responder: serves memory_bus reads/writes from an external fixed-latency BRAM (clk_in, rst_in, bus slave, ram_addr/ram_we/ram_wdata out, ram_rdata in)
module memory_bus_responder import mem_bus_pkg::*; #(
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  memory_bus.slave                 bus,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic                     ram_we,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata
);
  localparam int RAM_AW = $clog2(DEPTH);
  responder_state_t state, next;
  logic req, fault, start, done, fault_q;
  logic [DATA_WIDTH-1:0] rd_q;
  assign req   = state == IDLE && (bus.dispatch_read || bus.dispatch_write);
  assign fault = 32'(bus.addr) >= DEPTH;
  assign start = req && !bus.dispatch_write && !fault;
  mem_latency_counter #(.LATENCY(READ_LATENCY)) u_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .start  (start),
    .done   (done)
  );
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) state <= IDLE;
    else state <= next;
  // read_data bypasses ram_rdata in RESP so the BRAM output is seen in the same cycle; rd_q holds it afterwards
  always_comb begin
    next = state == IDLE ? (req ? (bus.dispatch_write ? WRITE : (fault ? RESP_FAULT : READ_WAIT)) : IDLE)
         : state == READ_WAIT ? (done ? RESP : READ_WAIT) : IDLE;
    bus.busy       = state != IDLE;
    bus.write_done = state == WRITE;
    bus.read_valid = state == RESP || state == RESP_FAULT;
    bus.addr_fault = fault_q && (state == WRITE || state == RESP_FAULT);
    bus.read_data  = state == RESP ? ram_rdata : (state == RESP_FAULT ? '0 : rd_q);
    ram_we         = state == WRITE && !fault_q;
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      fault_q     <= 1'b0;
      rd_q        <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      bus.dropped <= 1'b0;
    end else begin
      bus.dropped <= (state != IDLE && (bus.dispatch_read || bus.dispatch_write)) ||
                     (req && bus.dispatch_read && bus.dispatch_write);
      if (req) fault_q <= fault;
      if (req) ram_addr <= bus.addr[RAM_AW-1:0];
      if (req && bus.dispatch_write) ram_wdata <= bus.write_data;
      if (state == RESP || state == RESP_FAULT) rd_q <= bus.read_data;
    end
endmodule

// File: tb/tb_memory_bus_responder.sv
// tb_memory_bus_responder: table-driven check of memory_bus_responder against a 2-cycle BRAM model
module tb_memory_bus_responder;
  import mem_bus_pkg::*;
  logic clk, rst_in;
  logic [11:0] ram_addr;
  logic ram_we;
  logic [7:0] ram_wdata, ram_rdata;
  int checks = 0, errors = 0;
  memory_bus #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();
  memory_bus_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(4096), .READ_LATENCY(2)) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );
  logic [7:0] mem [4096];
  logic [7:0] s1, s2;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    s1 <= mem[ram_addr];
    s2 <= s1;
  end
  assign ram_rdata = s2;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic dr, dw; logic [15:0] a; logic [7:0] wd;
    logic [7:0] rd; logic rv, wdn, bsy, af, drp, we; logic [11:0] ra; logic [7:0] rw;
  } vec_t;
  vec_t tbl [34];
  function automatic logic [33:0] outs();
    return {bus.read_data, bus.read_valid, bus.write_done, bus.busy, bus.addr_fault, bus.dropped, ram_we, ram_addr, ram_wdata};
  endfunction
  task automatic chk(input string n, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic drive(input logic dr, input logic dw, input logic [15:0] a, input logic [7:0] wd);
    bus.dispatch_read = dr; bus.dispatch_write = dw; bus.addr = a; bus.write_data = wd;
  endtask
  task automatic read_check(input string n, input logic [15:0] a, input logic [7:0] exp);
    int lat;
    logic [7:0] got;
    lat = 0; got = 8'h00;
    @(posedge clk); #1 drive(1'b1, 1'b0, a, 8'h00);
    @(posedge clk); #1 drive(1'b0, 1'b0, 16'h0, 8'h00);
    for (int i = 0; i < 8 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.read_valid) begin lat = i + 1; got = bus.read_data; end
    end
    chk({n, "_latency"}, 34'(lat), 34'd3);
    chk({n, "_data"}, 34'(got), 34'(exp));
  endtask
  initial begin
    logic rv_seen;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    tbl = '{
      '{1'b0,1'b0,16'h0000,8'h00, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h000,8'h00},
      '{1'b0,1'b1,16'h0010,8'hA5, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h000,8'h00},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,12'h010,8'hA5},
      '{1'b1,1'b0,16'h0010,8'h00, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h010,8'hA5},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h010,8'hA5},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h010,8'hA5},
      '{1'b0,1'b0,16'h0000,8'h00, 8'hA5,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,12'h010,8'hA5},
      '{1'b0,1'b0,16'h0000,8'h00, 8'hA5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h010,8'hA5},
      '{1'b1,1'b0,16'h1000,8'h00, 8'hA5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h010,8'hA5},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h00,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,12'h000,8'hA5},
      '{1'b0,1'b1,16'h2000,8'h77, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h000,8'hA5},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h00,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,12'h000,8'h77},
      '{1'b1,1'b1,16'h0020,8'h3C, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h000,8'h77},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h00,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,12'h020,8'h3C},
      '{1'b1,1'b0,16'h0010,8'h00, 8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h020,8'h3C},
      '{1'b0,1'b1,16'h0010,8'hFF, 8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h010,8'h3C},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,12'h010,8'h3C},
      '{1'b0,1'b0,16'h0000,8'h00, 8'hA5,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,12'h010,8'h3C},
      '{1'b0,1'b0,16'h0000,8'h00, 8'hA5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h010,8'h3C},
      '{1'b1,1'b0,16'h0020,8'h00, 8'hA5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h010,8'h3C},
      '{1'b0,1'b0,16'h0000,8'h00, 8'hA5,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h020,8'h3C},
      '{1'b0,1'b0,16'h0000,8'h00, 8'hA5,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h020,8'h3C},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h3C,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,12'h020,8'h3C},
      '{1'b1,1'b0,16'h0010,8'h00, 8'h3C,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h020,8'h3C},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h3C,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h010,8'h3C},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h3C,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h010,8'h3C},
      '{1'b0,1'b0,16'h0000,8'h00, 8'hA5,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,12'h010,8'h3C},
      '{1'b0,1'b1,16'h0FFF,8'h5A, 8'hA5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h010,8'h3C},
      '{1'b0,1'b0,16'h0000,8'h00, 8'hA5,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,12'hFFF,8'h5A},
      '{1'b1,1'b0,16'h0FFF,8'h00, 8'hA5,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'hFFF,8'h5A},
      '{1'b0,1'b0,16'h0000,8'h00, 8'hA5,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'hFFF,8'h5A},
      '{1'b0,1'b0,16'h0000,8'h00, 8'hA5,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'hFFF,8'h5A},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h5A,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,12'hFFF,8'h5A},
      '{1'b0,1'b0,16'h0000,8'h00, 8'h5A,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'hFFF,8'h5A}
    };
    rst_in = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 8'h00);
    repeat (2) @(negedge clk);
    chk("reset_state", outs(), 34'd0);
    rst_in = 1'b1;
    for (int i = 0; i < 34; i++) begin
      @(posedge clk); #1 drive(tbl[i].dr, tbl[i].dw, tbl[i].a, tbl[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].rd, tbl[i].rv, tbl[i].wdn, tbl[i].bsy, tbl[i].af, tbl[i].drp, tbl[i].we, tbl[i].ra, tbl[i].rw});
    end
    @(posedge clk); #1 drive(1'b1, 1'b0, 16'h0020, 8'h00);
    @(posedge clk); #1 drive(1'b0, 1'b0, 16'h0, 8'h00);
    @(negedge clk);
    chk("busy_in_read_wait", 34'(bus.busy), 34'd1);
    #1 rst_in = 1'b0;
    #1 chk("reset_mid_read_outputs", outs(), 34'd0);
    @(negedge clk) rst_in = 1'b1;
    rv_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.read_valid) rv_seen = 1'b1;
    end
    chk("no_read_valid_after_reset", 34'(rv_seen), 34'd0);
    read_check("read_after_reset", 16'h0020, 8'h3C);
    @(posedge clk); #1 drive(1'b0, 1'b1, 16'h0030, 8'h11);
    @(posedge clk); #1 drive(1'b0, 1'b0, 16'h0, 8'h00);
    @(negedge clk);
    chk("ram_we_before_reset", 34'(ram_we), 34'd1);
    #1 rst_in = 1'b0;
    #1 chk("ram_we_dropped_on_reset", 34'(ram_we), 34'd0);
    @(negedge clk) rst_in = 1'b1;
    read_check("aborted_write_not_committed", 16'h0030, 8'h00);
    read_check("boundary_word", 16'h0FFF, 8'h5A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
